// File: rtl/len5_mem_pkg.sv
// len5_mem_pkg: access-size and splitter FSM types shared by the memory access splitter.
// Rev 1.0
`default_nettype none

package len5_mem_pkg;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2,
      SIZE_D = 2'd3
   } mem_size_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      REQ0 = 3'd1,
      RSP0 = 3'd2,
      REQ1 = 3'd3,
      RSP1 = 3'd4,
      DONE = 3'd5
   } split_state_t;

   function automatic logic [4:0] size_to_nbytes(input mem_size_t size);
      return 5'd1 << size;
   endfunction

endpackage

`default_nettype wire

// File: rtl/byte_mask_gen.sv
// byte_mask_gen: byte-enable masks for an access of nbytes at byte offset off, split across two beats.
// Rev 1.0
`default_nettype none

module byte_mask_gen
   import len5_mem_pkg::*;
#(
   parameter int DATA_BYTES = 8
) (
   input  logic [4:0]                    nbytes,
   input  logic [$clog2(DATA_BYTES)-1:0] off,
   output logic [DATA_BYTES-1:0]         mask0,
   output logic [DATA_BYTES-1:0]         mask1
);

   localparam int SPAN_W = 2 * DATA_BYTES;

   logic [SPAN_W-1:0] span;
   logic [SPAN_W-1:0] placed;

   // Placing the mask in a double-width window yields beat1's mask as the upper half.
   assign span   = (SPAN_W'(1) << nbytes) - SPAN_W'(1);
   assign placed = span << off;
   assign mask0  = placed[DATA_BYTES-1:0];
   assign mask1  = placed[SPAN_W-1:DATA_BYTES];

endmodule

`default_nettype wire

// File: rtl/mem_access_splitter.sv
// mem_access_splitter: turns one B/H/W/D access into one or two aligned memory beats.
// Define MEM_SPLIT_MISALIGNED_EN to split beat-crossing accesses; otherwise they return an error.
`default_nettype none

module mem_access_splitter
   import len5_mem_pkg::*;
#(
   parameter int DATA_BYTES = 8,
   parameter int ADDR_W     = 64
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [ADDR_W-1:0]       req_addr_i,
   input  logic                    req_we_i,
   input  logic [1:0]              req_size_i,
   input  logic [8*DATA_BYTES-1:0] req_wdata_i,
   output logic                    mem_valid_o,
   input  logic                    mem_ready_i,
   output logic [ADDR_W-1:0]       mem_addr_o,
   output logic                    mem_we_o,
   output logic [DATA_BYTES-1:0]   mem_be_o,
   output logic [8*DATA_BYTES-1:0] mem_wdata_o,
   input  logic                    mem_rvalid_i,
   input  logic [8*DATA_BYTES-1:0] mem_rdata_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [8*DATA_BYTES-1:0] rsp_rdata_o,
   output logic                    rsp_err_o
);

   localparam int         OFF_W = $clog2(DATA_BYTES);
   localparam int         DW    = 8 * DATA_BYTES;
   localparam logic [4:0] DB_N  = 5'(DATA_BYTES);

   split_state_t          state;
   logic [4:0]            nbytes;
   logic [OFF_W-1:0]      off;

   logic [4:0]            req_nbytes;
   logic [OFF_W-1:0]      req_off;
   logic [ADDR_W-1:0]     req_base;
   logic [DATA_BYTES-1:0] req_mask0;
   logic [DATA_BYTES-1:0] req_mask1;
   logic                  req_crossing;
   logic                  req_error;
   logic [DW-1:0]         len_mask;
   logic [DW-1:0]         beat0_data;

   assign req_nbytes = size_to_nbytes(mem_size_t'(req_size_i));
   assign req_off    = req_addr_i[OFF_W-1:0];
   assign req_base   = {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   byte_mask_gen #(
      .DATA_BYTES(DATA_BYTES)
   ) u_mask (
      .nbytes(req_nbytes),
      .off   (req_off),
      .mask0 (req_mask0),
      .mask1 (req_mask1)
   );

   // Any enable spilling into the upper mask means the access runs past this beat.
   assign req_crossing = |req_mask1;

`ifdef MEM_SPLIT_MISALIGNED_EN
   logic [OFF_W:0]        req_hi_shift;
   logic [OFF_W:0]        hi_shift;
   logic                  crossing;
   logic [ADDR_W-1:0]     b1_addr;
   logic [DATA_BYTES-1:0] b1_be;
   logic [DW-1:0]         b1_wdata;
   logic [DW-1:0]         acc;

   assign req_hi_shift = (OFF_W+1)'(DATA_BYTES) - {1'b0, req_off};
   assign hi_shift     = (OFF_W+1)'(DATA_BYTES) - {1'b0, off};
   assign req_error    = req_nbytes > DB_N;
`else
   assign req_error    = (req_nbytes > DB_N) || req_crossing;
`endif

   always_comb begin
      len_mask = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (5'(i) < nbytes) len_mask[8*i +: 8] = 8'hFF;
      end
   end

   assign beat0_data = (mem_rdata_i >> {off, 3'b000}) & len_mask;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         req_ready_o <= 1'b1;
         mem_valid_o <= 1'b0;
         mem_addr_o  <= '0;
         mem_we_o    <= 1'b0;
         mem_be_o    <= '0;
         mem_wdata_o <= '0;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
         nbytes      <= '0;
         off         <= '0;
`ifdef MEM_SPLIT_MISALIGNED_EN
         crossing    <= 1'b0;
         b1_addr     <= '0;
         b1_be       <= '0;
         b1_wdata    <= '0;
         acc         <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  req_ready_o <= 1'b0;
                  nbytes      <= req_nbytes;
                  off         <= req_off;
                  mem_we_o    <= req_we_i;
                  if (req_error) begin
                     state       <= DONE;
                     rsp_valid_o <= 1'b1;
                     rsp_err_o   <= 1'b1;
                     rsp_rdata_o <= '0;
                  end else begin
                     state       <= REQ0;
                     mem_valid_o <= 1'b1;
                     mem_addr_o  <= req_base;
                     mem_be_o    <= req_mask0;
                     mem_wdata_o <= req_wdata_i << {req_off, 3'b000};
                  end
`ifdef MEM_SPLIT_MISALIGNED_EN
                  crossing <= req_crossing;
                  b1_addr  <= req_base + ADDR_W'(DATA_BYTES);
                  b1_be    <= req_mask1;
                  b1_wdata <= req_wdata_i >> {req_hi_shift, 3'b000};
`endif
               end
            end
            REQ0: begin
               if (mem_ready_i) begin
                  mem_valid_o <= 1'b0;
                  state       <= RSP0;
               end
            end
            RSP0: begin
               if (mem_rvalid_i) begin
`ifdef MEM_SPLIT_MISALIGNED_EN
                  if (crossing) begin
                     acc         <= beat0_data;
                     state       <= REQ1;
                     mem_valid_o <= 1'b1;
                     mem_addr_o  <= b1_addr;
                     mem_be_o    <= b1_be;
                     mem_wdata_o <= b1_wdata;
                  end else
`endif
                  begin
                     state       <= DONE;
                     rsp_valid_o <= 1'b1;
                     rsp_err_o   <= 1'b0;
                     rsp_rdata_o <= mem_we_o ? '0 : beat0_data;
                  end
               end
            end
`ifdef MEM_SPLIT_MISALIGNED_EN
            REQ1: begin
               if (mem_ready_i) begin
                  mem_valid_o <= 1'b0;
                  state       <= RSP1;
               end
            end
            RSP1: begin
               if (mem_rvalid_i) begin
                  state       <= DONE;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b0;
                  rsp_rdata_o <= mem_we_o ? '0
                                 : ((acc | (mem_rdata_i << {hi_shift, 3'b000})) & len_mask);
               end
            end
`endif
            DONE: begin
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  rsp_err_o   <= 1'b0;
                  rsp_rdata_o <= '0;
                  req_ready_o <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               state       <= IDLE;
               req_ready_o <= 1'b1;
               mem_valid_o <= 1'b0;
               rsp_valid_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_splitter.sv
// tb_mem_access_splitter: scoreboard bench for mem_access_splitter (DATA_BYTES=8, ADDR_W=64).
// Expectations follow MEM_SPLIT_MISALIGNED_EN as defined for the build.
`default_nettype none

module tb_mem_access_splitter;
   import len5_mem_pkg::*;

   localparam int LAT = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid_i;
   logic        req_ready_o;
   logic [63:0] req_addr_i;
   logic        req_we_i;
   logic [1:0]  req_size_i;
   logic [63:0] req_wdata_i;
   logic        mem_valid_o;
   logic        mem_ready_i;
   logic [63:0] mem_addr_o;
   logic        mem_we_o;
   logic [7:0]  mem_be_o;
   logic [63:0] mem_wdata_o;
   logic        mem_rvalid_i;
   logic [63:0] mem_rdata_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [63:0] rsp_rdata_o;
   logic        rsp_err_o;

   always #5 clk = ~clk;

   mem_access_splitter #(
      .DATA_BYTES(8),
      .ADDR_W    (64)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_addr_i  (req_addr_i),
      .req_we_i    (req_we_i),
      .req_size_i  (req_size_i),
      .req_wdata_i (req_wdata_i),
      .mem_valid_o (mem_valid_o),
      .mem_ready_i (mem_ready_i),
      .mem_addr_o  (mem_addr_o),
      .mem_we_o    (mem_we_o),
      .mem_be_o    (mem_be_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rvalid_i(mem_rvalid_i),
      .mem_rdata_i (mem_rdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_ready_i (rsp_ready_i),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o)
   );

   typedef struct {
      logic [63:0] addr;
      logic        we;
      logic [7:0]  be;
      logic [63:0] wdata;
      logic [63:0] rdata;
   } beat_t;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
   } rsp_t;

   beat_t beat_q[$];
   rsp_t  rsp_q[$];
   int    errors = 0;
   int    checks = 0;
   int    cyc    = 0;

   function automatic void exp_beat(input logic [63:0] addr, input logic we, input logic [7:0] be,
                                    input logic [63:0] wdata, input logic [63:0] rdata);
      beat_q.push_back('{addr: addr, we: we, be: be, wdata: wdata, rdata: rdata});
   endfunction

   function automatic void exp_rsp(input logic [63:0] rdata, input logic err);
      rsp_q.push_back('{rdata: rdata, err: err});
   endfunction

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Handshake stall patterns on the memory and response sides.
   initial begin
      mem_ready_i = 1'b0;
      rsp_ready_i = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         mem_ready_i = (cyc % 3) != 0;
         rsp_ready_i = (cyc % 2) == 0;
      end
   end

   // Beat monitor and memory responder.
   initial begin
      int          pend;
      logic [63:0] pdata;
      beat_t       e;
      pend         = 0;
      pdata        = '0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      forever begin
         @(negedge clk);
         if (mem_valid_o && mem_ready_i) begin
            checks++;
            if (beat_q.size() == 0) begin
               errors++;
               $display("FAIL beat_unexpected: addr=%h be=%h", mem_addr_o, mem_be_o);
               pdata = '0;
            end else begin
               e = beat_q.pop_front();
               if ({mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o} !== {e.addr, e.we, e.be, e.wdata}) begin
                  errors++;
                  $display("FAIL beat: got addr=%h we=%b be=%h wdata=%h expected addr=%h we=%b be=%h wdata=%h",
                           mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o, e.addr, e.we, e.be, e.wdata);
               end
               pdata = e.rdata;
            end
            pend = LAT;
         end
         @(posedge clk);
         #1;
         mem_rvalid_i = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               mem_rvalid_i = 1'b1;
               mem_rdata_i  = pdata;
            end
         end
      end
   end

   // Response monitor.
   initial begin
      rsp_t e;
      forever begin
         @(negedge clk);
         if (rsp_valid_o && rsp_ready_i) begin
            checks++;
            if (rsp_q.size() == 0) begin
               errors++;
               $display("FAIL rsp_unexpected: rdata=%h err=%b", rsp_rdata_o, rsp_err_o);
            end else begin
               e = rsp_q.pop_front();
               if ({rsp_rdata_o, rsp_err_o} !== {e.rdata, e.err}) begin
                  errors++;
                  $display("FAIL rsp: got rdata=%h err=%b expected rdata=%h err=%b",
                           rsp_rdata_o, rsp_err_o, e.rdata, e.err);
               end
            end
         end
      end
   end

   task automatic issue(input logic [63:0] addr, input logic we, input logic [1:0] size,
                        input logic [63:0] wdata);
      bit seen;
      seen = 1'b0;
      @(posedge clk);
      #1;
      req_valid_i = 1'b1;
      req_addr_i  = addr;
      req_we_i    = we;
      req_size_i  = size;
      req_wdata_i = wdata;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         if (req_ready_o) seen = 1'b1;
      end
      @(posedge clk);
      #1;
      req_valid_i = 1'b0;
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: req_ready_o=%b required 1", req_ready_o);
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((rsp_q.size() != 0 || beat_q.size() != 0 || !req_ready_o) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: pending beats=%0d rsps=%0d required 0", name,
                  beat_q.size(), rsp_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst         = 1'b1;
      req_valid_i = 1'b0;
      req_addr_i  = '0;
      req_we_i    = 1'b0;
      req_size_i  = 2'd0;
      req_wdata_i = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {req_ready_o, mem_valid_o, rsp_valid_o, rsp_err_o, mem_be_o},
            {1'b1, 1'b0, 1'b0, 1'b0, 8'h00});
      rst = 1'b0;

      // D read, aligned
      exp_beat(64'h1000, 1'b0, 8'hFF, 64'h0, 64'h0123456789ABCDEF);
      exp_rsp(64'h0123456789ABCDEF, 1'b0);
      issue(64'h1000, 1'b0, SIZE_D, 64'h0);
      drain("d_read");

      // W write crossing at 0x1006
`ifdef MEM_SPLIT_MISALIGNED_EN
      exp_beat(64'h1000, 1'b1, 8'hC0, 64'hCCDD000000000000, 64'hDEAD);
      exp_beat(64'h1008, 1'b1, 8'h03, 64'h000000000000AABB, 64'hBEEF);
      exp_rsp(64'h0, 1'b0);
`else
      exp_rsp(64'h0, 1'b1);
`endif
      issue(64'h1006, 1'b1, SIZE_W, 64'hAABBCCDD);
      drain("w_write_cross");

      // H read crossing at 0x2007
`ifdef MEM_SPLIT_MISALIGNED_EN
      exp_beat(64'h2000, 1'b0, 8'h80, 64'h0, 64'h11FFEEDDCCBBAA99);
      exp_beat(64'h2008, 1'b0, 8'h01, 64'h0, 64'h9988776655443322);
      exp_rsp(64'h2211, 1'b0);
`else
      exp_rsp(64'h0, 1'b1);
`endif
      issue(64'h2007, 1'b0, SIZE_H, 64'h0);
      drain("h_read_cross");

      // W read crossing at 0x1006
`ifdef MEM_SPLIT_MISALIGNED_EN
      exp_beat(64'h1000, 1'b0, 8'hC0, 64'h0, 64'h4433111111111111);
      exp_beat(64'h1008, 1'b0, 8'h03, 64'h0, 64'hFFFFFFFFFFFF6655);
      exp_rsp(64'h66554433, 1'b0);
      issue(64'h1006, 1'b0, SIZE_W, 64'h0);
`else
      exp_rsp(64'h0, 1'b1);
      issue(64'h1006, 1'b0, SIZE_W, 64'h0);
      @(negedge clk);
      check("err_one_cycle", {mem_valid_o, rsp_valid_o, rsp_err_o, rsp_rdata_o},
            {1'b0, 1'b1, 1'b1, 64'h0});
`endif
      drain("w_read_cross");

      // H read at top of address space: beat1 wraps to 0
`ifdef MEM_SPLIT_MISALIGNED_EN
      exp_beat(64'hFFFFFFFFFFFFFFF8, 1'b0, 8'h80, 64'h0, 64'hAB00000000000000);
      exp_beat(64'h0000000000000000, 1'b0, 8'h01, 64'h0, 64'h00000000000000CD);
      exp_rsp(64'hCDAB, 1'b0);
`else
      exp_rsp(64'h0, 1'b1);
`endif
      issue(64'hFFFFFFFFFFFFFFFF, 1'b0, SIZE_H, 64'h0);
      drain("h_read_wrap");

      // Non-crossing misaligned accesses
      exp_beat(64'h1000, 1'b0, 8'hF0, 64'h0, 64'h8877665544332211);
      exp_rsp(64'h88776655, 1'b0);
      issue(64'h1004, 1'b0, SIZE_W, 64'h0);
      drain("w_read_off4");

      exp_beat(64'h1000, 1'b1, 8'h08, 64'h000000005A000000, 64'h1234);
      exp_rsp(64'h0, 1'b0);
      issue(64'h1003, 1'b1, SIZE_B, 64'h5A);
      drain("b_write_off3");

      exp_beat(64'h2000, 1'b0, 8'hC0, 64'h0, 64'hBEEF000000000000);
      exp_rsp(64'hBEEF, 1'b0);
      issue(64'h2006, 1'b0, SIZE_H, 64'h0);
      drain("h_read_off6");

      // Reset while waiting for the beat response
      exp_beat(64'h4000, 1'b0, 8'hFF, 64'h0, 64'h5555);
      issue(64'h4000, 1'b0, SIZE_D, 64'h0);
      n = 0;
      while (beat_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL rst_beat_timeout: pending beats=%0d required 0", beat_q.size());
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid_rsp0",
            {req_ready_o, mem_valid_o, mem_we_o, rsp_valid_o, rsp_err_o, mem_be_o, mem_addr_o, rsp_rdata_o},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 64'h0});
      #1;
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check("late_rvalid_ignored", {req_ready_o, rsp_valid_o, mem_valid_o}, {1'b1, 1'b0, 1'b0});

      exp_beat(64'h3000, 1'b0, 8'hFF, 64'h0, 64'hCAFEF00D12345678);
      exp_rsp(64'hCAFEF00D12345678, 1'b0);
      issue(64'h3000, 1'b0, SIZE_D, 64'h0);
      drain("d_read_after_rst");

      check("beat_queue_empty", 192'(beat_q.size()), 192'(0));
      check("rsp_queue_empty", 192'(rsp_q.size()), 192'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mem_access_splitter.md
MEM_ACCESS_SPLITTER -- requirements
Module: mem_access_splitter

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 8, giving the bytes per memory beat (power of two, 4..16).
REQ-002 SHALL have parameter ADDR_W, default 64, giving the address width.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_i, input, 1, an asynchronous active-high reset.
REQ-005 SHALL have ports req_valid_i in 1, req_ready_o out 1, req_addr_i in ADDR_W, req_we_i in 1, req_size_i in 2 (0=B, 1=H, 2=W, 3=D), req_wdata_i in 8*DATA_BYTES, forming the upstream request.
REQ-006 SHALL have ports mem_valid_o out 1, mem_ready_i in 1, mem_addr_o out ADDR_W, mem_we_o out 1, mem_be_o out DATA_BYTES, mem_wdata_o out 8*DATA_BYTES, forming the memory beat.
REQ-007 SHALL have ports mem_rvalid_i in 1 and mem_rdata_i in 8*DATA_BYTES, carrying the beat response (also the write ack).
REQ-008 SHALL have ports rsp_valid_o out 1, rsp_ready_i in 1, rsp_rdata_o out 8*DATA_BYTES, rsp_err_o out 1, forming the upstream response.

Function
REQ-009 SHALL use FSM states IDLE, REQ0, RSP0, REQ1, RSP1, DONE; req_ready_o=1 only in IDLE.
REQ-010 SHALL capture the request on req_valid_i&req_ready_o and move to REQ0 (or DONE on error) the next cycle.
REQ-011 SHALL define nbytes=1<<req_size_i, off=addr mod DATA_BYTES, and crossing=(off+nbytes>DATA_BYTES).
REQ-012 SHALL flag nbytes>DATA_BYTES as an error: no memory beat, DONE with rsp_err_o=1, rsp_rdata_o=0.
REQ-013 SHALL drive beat0 as: mem_addr_o=addr with low log2(DATA_BYTES) bits cleared; mem_be_o=((1<<nbytes)-1)<<off truncated; mem_wdata_o=wdata<<8*off.
REQ-014 SHALL drive beat1 (crossing only) as: addr=beat0 addr+DATA_BYTES modulo 2^ADDR_W; be=mask>>(DATA_BYTES-off); wdata=wdata>>8*(DATA_BYTES-off).
REQ-015 SHALL hold mem_valid_o and all beat fields stable in REQx until mem_ready_i, then move to RSPx.
REQ-016 SHALL keep at most one beat outstanding; RSP0 waits for mem_rvalid_i, then goes to REQ1 if crossing, else DONE.
REQ-017 SHALL assemble rsp_rdata_o right-aligned and zero-extended: beat0 bytes off..DATA_BYTES-1 to the low bytes, beat1 bytes above them, unused bytes 0; write responses return 0.
REQ-018 SHALL hold rsp_valid_o in DONE until rsp_ready_i, then return to IDLE; no same-cycle re-accept.
REQ-019 SHALL ignore mem_rvalid_i in IDLE, REQx and DONE.
REQ-020 SHALL latch mem_ready_i and mem_rvalid_i high in the same cycle as ready only; the response is taken on a later cycle in RSPx.

Reset
REQ-021 SHALL on rst_i, asynchronously, set state IDLE and drive all outputs 0 except req_ready_o=1, mid-operation included; an in-flight beat response arriving after reset SHALL be ignored.

Configuration
REQ-022 SHALL, with MEM_SPLIT_MISALIGNED_EN defined, split crossing accesses per REQ-014.
REQ-023 SHALL, without MEM_SPLIT_MISALIGNED_EN, issue no beat for a crossing access, go directly to DONE with rsp_err_o=1 and rsp_rdata_o=0, and omit the REQ1/RSP1 logic.

Structure
REQ-024 SHALL place mem_size_t (B/H/W/D) and the FSM state typedef in shared package len5_mem_pkg.
REQ-025 SHALL compute byte masks in combinational sub-module byte_mask_gen (inputs nbytes and off; outputs beat0 and beat1 masks).

Verification (DATA_BYTES=8, ADDR_W=64)
REQ-026 SHALL cover: D read at 0x1000 -> one beat, addr 0x1000, be 0xFF; rdata passed through, err 0.
REQ-027 SHALL cover: W write 0xAABBCCDD at 0x1006, macro on -> beat0 0x1000 be 0xC0 wdata 0xCCDD000000000000; beat1 0x1008 be 0x03 wdata 0xAABB.
REQ-028 SHALL cover: H read at 0x2007, beat0 byte7=0x11, beat1 byte0=0x22 -> be 0x80 then 0x01; rsp_rdata_o=0x2211.
REQ-029 SHALL cover: macro off, W read at 0x1006 -> no mem_valid_o, rsp_err_o=1, rsp_rdata_o=0 one cycle after accept.
REQ-030 SHALL cover: H read at 0xFFFFFFFFFFFFFFFF (macro on) -> beat1 addr 0x0000000000000000.
REQ-031 SHALL cover: rst_i pulse while in RSP0 -> outputs reset immediately, late mem_rvalid_i ignored, next D read at 0x3000 completes normally.
